// File: rtl/demux_pkg.sv
// Shared types and defaults for the 1:N handshake demux.
// Holds the per-slot state encoding and the select-width helper.
package demux_pkg;

    localparam int DEMUX_WIDTH_DEF = 8;
    localparam int DEMUX_NCH_DEF   = 4;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Select width never collapses to zero, even for tiny channel counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_1_n_hs_if.sv
// Producer-side and consumer-side handshake bundle of the 1:N demux.
// Master drives input words and consumer readies; slave is the demux itself.
interface demux_1_n_hs_if
    import demux_pkg::*;
#(
    parameter int WIDTH  = DEMUX_WIDTH_DEF,
    parameter int NUM_CH = DEMUX_NCH_DEF,
    parameter int SEL_W  = clog2_min1(NUM_CH)
);
    logic [WIDTH-1:0]        in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_bcast;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH-1:0]       out_ready;

    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/demux_slot.sv
// One-entry output holding register; write lands 1 cycle later.
// Accepts a new word when empty or when its consumer drains it in the same cycle.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can_accept
);
    slot_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // A write wins over a read: read+write keeps the slot full with new data.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (wr_en) begin
            state_d = SLOT_FULL;
            data_d  = wr_data;
        end else if (state_q == SLOT_FULL && rd_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    assign valid      = (state_q == SLOT_FULL);
    assign data       = data_q;
    assign can_accept = !valid || rd_ready;

endmodule

// File: rtl/demux_1_n_hs.sv
// Registered 1:N demux with unicast/broadcast routing, 1-cycle latency.
// in_ready follows only the addressed slot(s); out-of-range selects are sunk and counted.
module demux_1_n_hs
    import demux_pkg::*;
#(
    parameter int WIDTH  = DEMUX_WIDTH_DEF,
    parameter int NUM_CH = DEMUX_NCH_DEF,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    demux_1_n_hs_if.slave    bus,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int SEL_W = clog2_min1(NUM_CH);

    logic [NUM_CH-1:0] can_acc;
    logic [NUM_CH-1:0] sel_hit;
    logic [NUM_CH-1:0] wr_en;
    logic              sel_acc;
    logic              in_range;
    logic              in_ready;
    logic              accept;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        sel_hit = '0;
        sel_acc = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                sel_hit[k] = 1'b1;
                sel_acc    = can_acc[k];
            end
        end
        in_range = |sel_hit;

        if (rst) begin
            in_ready = 1'b0;
        end else if (bus.in_bcast) begin
            in_ready = &can_acc;
        end else if (in_range) begin
            in_ready = sel_acc;
        end else begin
            in_ready = 1'b1;
        end

        accept = bus.in_valid && in_ready;
        wr_en  = {NUM_CH{accept && bus.in_bcast}} | (sel_hit & {NUM_CH{accept}});

        err_cnt_d = err_cnt_q;
        if (accept && !bus.in_bcast && !in_range && err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign err_cnt      = err_cnt_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (wr_en[g]),
            .wr_data    (bus.in_data),
            .rd_ready   (bus.out_ready[g]),
            .valid      (bus.out_valid[g]),
            .data       (bus.out_data[g*WIDTH +: WIDTH]),
            .can_accept (can_acc[g])
        );
    end

endmodule
